// File: rtl/spiker_seq_pkg.sv
// spiker_seq_pkg: shared types and defaults for the spiker run sequencer.
//   STEP_W_DEF         default width of the timestep counter
//   TIMEOUT_CYCLES_DEF default per-step watchdog limit (SPIKER_SEQ_TIMEOUT_EN builds)
//   state_e            sequencer FSM state encoding
package spiker_seq_pkg;
    localparam int STEP_W_DEF         = 16;
    localparam int TIMEOUT_CYCLES_DEF = 4096;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_WAIT,
        S_SAMPLE,
        S_DONE,
        S_ERR
    } state_e;
endpackage

// File: rtl/spiker_seq_watchdog.sv
// spiker_seq_watchdog: counts cycles spent waiting for the core on one timestep.
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   run_i      high while the sequencer waits for core_done; low clears the count
//   expired_o  high in the wait cycle that completes TIMEOUT_CYCLES of waiting
module spiker_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    // The count is 0 in the first wait cycle, so expiry at TIMEOUT_CYCLES-1 puts the
    // error state exactly TIMEOUT_CYCLES cycles after wait entry.
    assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= (run_i && !expired_o) ? cnt_q + 1'b1 : '0;
    end
endmodule

// File: rtl/spiker_sequencer.sv
// spiker_sequencer: runs the spiker core for n_steps timesteps (clear, step/wait loop, sample).
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   start_i, n_steps_i     run request and timestep count (latched on accepted start)
//   abort_i, ack_i         cancel a run; acknowledge DONE/ERR
//   core_done_i            core finished the current timestep
//   core_clear_o, core_step_o, sample_o   one-cycle core control pulses
//   busy_o, done_o, err_o, irq_o          status levels and completion interrupt pulse
//   step_cnt_o             completed timesteps of the current or last run
// Optional: define SPIKER_SEQ_TIMEOUT_EN to add the per-step watchdog and the ERR path.
module spiker_sequencer
    import spiker_seq_pkg::*;
#(
    parameter int STEP_W         = STEP_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [STEP_W-1:0] n_steps_i,
    input  logic              abort_i,
    input  logic              ack_i,
    input  logic              core_done_i,
    output logic              core_clear_o,
    output logic              core_step_o,
    output logic              sample_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              irq_o,
    output logic [STEP_W-1:0] step_cnt_o
);
    state_e            state_q, state_d;
    logic [STEP_W-1:0] n_q, n_d, cnt_d;
    logic              active, abort_go, timeout;
    assign active   = state_q inside {S_CLEAR, S_STEP, S_WAIT, S_SAMPLE};
    assign abort_go = abort_i && active;
`ifdef SPIKER_SEQ_TIMEOUT_EN
    spiker_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_i    (state_q == S_WAIT),
        .expired_o(timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = step_cnt_o;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && n_steps_i != '0) begin
                    n_d     = n_steps_i;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = S_STEP;
            S_STEP:   state_d = S_WAIT;
            S_WAIT: begin
                if (core_done_i) begin
                    cnt_d   = (step_cnt_o == n_q) ? step_cnt_o : step_cnt_o + 1'b1;
                    state_d = (cnt_d == n_q) ? S_SAMPLE : S_STEP;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_SAMPLE: state_d = S_DONE;
            S_DONE, S_ERR: state_d = ack_i ? S_IDLE : state_q;
            default:  state_d = S_IDLE;
        endcase
        // Abort overrides whatever the step logic decided, including a completed timestep.
        if (abort_go) begin
            state_d = S_IDLE;
            cnt_d   = step_cnt_o;
        end
    end
    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            step_cnt_o   <= '0;
            core_clear_o <= 1'b0;
            core_step_o  <= 1'b0;
            sample_o     <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            step_cnt_o   <= cnt_d;
            core_clear_o <= (state_d == S_CLEAR) || abort_go;
            core_step_o  <= state_d == S_STEP;
            sample_o     <= state_d == S_SAMPLE;
            busy_o       <= state_d inside {S_CLEAR, S_STEP, S_WAIT, S_SAMPLE};
            done_o       <= state_d == S_DONE;
            irq_o        <= (state_d inside {S_DONE, S_ERR}) && (state_d != state_q);
        end
    end
`ifdef SPIKER_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            err_o <= 1'b0;
        else
            err_o <= state_d == S_ERR;
    end
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_spiker_sequencer.sv
// tb_spiker_sequencer: randomized self-checking bench for spiker_sequencer.
module tb_spiker_sequencer;
    localparam int W   = 16;
    localparam int TMO = 16;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic         start_i = 1'b0, abort_i = 1'b0, ack_i = 1'b0, core_done_i = 1'b0;
    logic [W-1:0] n_steps_i = '0;
    logic         core_clear_o, core_step_o, sample_o, busy_o, done_o, err_o, irq_o;
    logic [W-1:0] step_cnt_o;
    spiker_sequencer #(
        .STEP_W        (W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .n_steps_i   (n_steps_i),
        .abort_i     (abort_i),
        .ack_i       (ack_i),
        .core_done_i (core_done_i),
        .core_clear_o(core_clear_o),
        .core_step_o (core_step_o),
        .sample_o    (sample_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .irq_o       (irq_o),
        .step_cnt_o  (step_cnt_o)
    );
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;
    int q_clear[$], q_step[$], q_sample[$], q_irq[$], q_done[$], q_err[$], q_busy[$];
    always @(negedge clk_i) begin
        if (core_clear_o) q_clear.push_back(cyc);
        if (core_step_o)  q_step.push_back(cyc);
        if (sample_o)     q_sample.push_back(cyc);
        if (irq_o)        q_irq.push_back(cyc);
        if (done_o)       q_done.push_back(cyc);
        if (err_o)        q_err.push_back(cyc);
        if (busy_o)       q_busy.push_back(cyc);
    end
    int n_checks = 0, n_pass = 0;
    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask
    function automatic int first_of(input int q[$]);
        return q.size() > 0 ? q[0] : -1;
    endfunction
    task automatic clear_logs();
        q_clear.delete(); q_step.delete(); q_sample.delete(); q_irq.delete();
        q_done.delete(); q_err.delete(); q_busy.delete();
    endtask
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask
    // One run: the whole pulse schedule is computed up front from the timing rules
    // (clear at t0+1, first step at t0+2, next step one cycle after each done, sample
    // one cycle after the last done, DONE/irq one cycle later), then driven open-loop.
    task automatic run(input int n, input int abort_at, input int dly);
        int t0, ab, last, c;
        int s[$], dn[$];
        bit hit;
        clear_logs();
        t0 = cyc;
        s.push_back(t0 + 2);
        for (int j = 0; j < n; j++) begin
            dn.push_back(s[j] + (dly > 0 ? dly : int'($urandom_range(1, 5))));
            if (j < n - 1) s.push_back(dn[j] + 1);
        end
        ab   = abort_at > 0 ? dn[abort_at-1] : -1;
        last = ab >= 0 ? ab + 3 : dn[n-1] + 3;
        while (cyc < last) begin
            c   = cyc;
            hit = 1'b0;
            foreach (dn[j]) if (dn[j] == c && (ab < 0 || c <= ab)) hit = 1'b1;
            start_i     = (c == t0) || (c > t0 && (ab < 0 || c <= ab) && $urandom_range(0, 3) == 0);
            n_steps_i   = (c == t0) ? W'(n) : W'($urandom_range(0, 9));
            core_done_i = hit || (c == t0 + 1) || (c > t0 + 2 && $urandom_range(0, 5) == 0 && c < s[0] + 1);
            abort_i     = (c == ab);
            tick();
        end
        start_i = 0; core_done_i = 0; abort_i = 0;
        check("step_pulses", q_step.size(), abort_at > 0 ? abort_at : n);
        foreach (s[j]) if (j < q_step.size()) check("step_cyc", q_step[j], s[j]);
        check("err_none", q_err.size(), 0);
        if (ab >= 0) begin
            check("abort_clears", q_clear.size(), 2);
            check("abort_clear_cyc", q_clear.size() > 1 ? q_clear[1] : -1, ab + 1);
            check("abort_sample", q_sample.size(), 0);
            check("abort_irq", q_irq.size(), 0);
            check("abort_busy_cycles", q_busy.size(), ab - t0);
            check("abort_step_cnt", step_cnt_o, abort_at - 1);
            check("abort_done", done_o, 0);
        end else begin
            check("clear_cnt", q_clear.size(), 1);
            check("clear_cyc", first_of(q_clear), t0 + 1);
            check("sample_cnt", q_sample.size(), 1);
            check("sample_cyc", first_of(q_sample), dn[n-1] + 1);
            check("irq_cnt", q_irq.size(), 1);
            check("irq_cyc", first_of(q_irq), dn[n-1] + 2);
            check("done_cyc", first_of(q_done), dn[n-1] + 2);
            check("busy_cycles", q_busy.size(), dn[n-1] + 1 - t0);
            check("step_cnt", step_cnt_o, n);
            check("done_lvl", done_o, 1);
            // Start together with ack must be ignored; count holds after DONE.
            ack_i = 1; start_i = 1; n_steps_i = W'(7);
            tick();
            ack_i = 0; start_i = 0;
            tick();
            tick();
            check("ack_done", done_o, 0);
            check("ack_busy", busy_o, 0);
            check("ack_start_ignored", q_clear.size(), 1);
            check("hold_step_cnt", step_cnt_o, n);
            check("irq_once", q_irq.size(), 1);
        end
    endtask
    initial begin
        int n;
        rst_ni = 1'b0;
        tick();
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_clear", core_clear_o, 0);
        check("rst_step", core_step_o, 0);
        check("rst_done", done_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_err", err_o, 0);
        check("rst_step_cnt", step_cnt_o, 0);
        rst_ni = 1'b1;
        tick();
        // Zero-length start is ignored entirely.
        clear_logs();
        start_i = 1; n_steps_i = '0;
        tick();
        start_i = 0;
        repeat (4) tick();
        check("zero_toggles", q_clear.size() + q_step.size() + q_busy.size() + q_irq.size() + q_sample.size(), 0);
        check("zero_step_cnt", step_cnt_o, 0);
        run(3, 0, 4);
        run(5, 2, -1);
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 6);
            run(n, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0, -1);
        end
        // Asynchronous reset in the middle of a wait.
        clear_logs();
        start_i = 1; n_steps_i = W'(3);
        tick();
        start_i = 0;
        tick();
        tick();
        core_done_i = 1;
        tick();
        core_done_i = 0;
        tick();
        tick();
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_step_cnt", step_cnt_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_busy", busy_o, 0);
        check("async_rst_step_cnt", step_cnt_o, 0);
        check("async_rst_outs", {core_clear_o, core_step_o, sample_o, done_o, err_o, irq_o}, 0);
        tick();
        rst_ni = 1'b1;
        run(2, 0, -1);
`ifdef SPIKER_SEQ_TIMEOUT_EN
        begin
            int t0;
            clear_logs();
            t0 = cyc;
            start_i = 1; n_steps_i = W'(2);
            tick();
            start_i = 0;
            repeat (TMO + 5) tick();
            check("tmo_err_cyc", first_of(q_err), t0 + 3 + TMO);
            check("tmo_irq_cyc", first_of(q_irq), t0 + 3 + TMO);
            check("tmo_sample", q_sample.size(), 0);
            ack_i = 1;
            tick();
            ack_i = 0;
            tick();
            check("tmo_ack_err", err_o, 0);
            check("tmo_ack_busy", busy_o, 0);
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spiker_sequencer.md
SPIKER_SEQUENCER -- requirements
Module: spiker_sequencer

Interface
REQ-001 Parameter STEP_W, default 16, width of the timestep count.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, maximum wait cycles per timestep (only used with the watchdog).
REQ-003 clk_i  in  1  clock; all logic on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  single-cycle run request from the register file.
REQ-006 n_steps_i  in  STEP_W  timesteps per run; sampled only on an accepted start.
REQ-007 abort_i  in  1  cancel the current run.
REQ-008 ack_i  in  1  software acknowledge of DONE or ERR.
REQ-009 core_done_i  in  1  spiker core finished the current timestep (pulse).
REQ-010 core_clear_o  out  1  one-cycle pulse that clears core membrane state.
REQ-011 core_step_o  out  1  one-cycle pulse that launches one timestep.
REQ-012 sample_o  out  1  one-cycle pulse that captures the spike result into the result registers.
REQ-013 busy_o  out  1  high in every state except IDLE, DONE and ERR.
REQ-014 done_o  out  1  level, high in DONE.
REQ-015 err_o  out  1  level, high in ERR.
REQ-016 irq_o  out  1  one-cycle pulse on entry to DONE or ERR.
REQ-017 step_cnt_o  out  STEP_W  number of completed timesteps in the current or last run.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, STEP, WAIT, SAMPLE, DONE and ERR; all outputs SHALL be registered.
REQ-019 IDLE: start_i=1 with n_steps_i!=0 SHALL latch n_steps_i, zero step_cnt_o and go to CLEAR; start_i with n_steps_i==0 SHALL be ignored.
REQ-020 CLEAR: core_clear_o=1 for exactly one cycle, then go to STEP.
REQ-021 STEP: core_step_o=1 for exactly one cycle, then go to WAIT.
REQ-022 WAIT: on core_done_i, step_cnt_o SHALL increment; if the new count equals the latched n_steps the FSM goes to SAMPLE, otherwise to STEP.
REQ-023 Latency: with start_i at cycle 0 the outputs SHALL be core_clear_o at cycle 1 and core_step_o at cycle 2. core_done_i at cycle k on the last step SHALL give sample_o at k+1 and done_o with irq_o at k+2.
REQ-024 SAMPLE: sample_o=1 for one cycle, then go to DONE.
REQ-025 DONE/ERR: the state SHALL hold until ack_i, then return to IDLE; start_i SHALL be ignored in the same cycle as ack_i and whenever the FSM is not in IDLE.
REQ-026 abort_i in CLEAR, STEP, WAIT or SAMPLE SHALL go to IDLE on the next edge and pulse core_clear_o; it SHALL assert no sample_o and no irq_o. abort_i has priority over core_done_i and the timeout.
REQ-027 core_done_i outside WAIT SHALL be ignored.
REQ-028 step_cnt_o SHALL saturate at the latched n_steps and SHALL hold its value after DONE until the next accepted start.

Reset
REQ-029 Asserting rst_ni at any time, including mid-run, SHALL force IDLE, all pulse and level outputs to 0, step_cnt_o to 0 and the latched n_steps to 0.
REQ-030 The first accepted start SHALL be on the first edge after rst_ni is released.

Configuration
REQ-031 With SPIKER_SEQ_TIMEOUT_EN defined, a per-step counter SHALL clear on entry to WAIT. If it reaches TIMEOUT_CYCLES without core_done_i, the FSM SHALL go to ERR (err_o=1, irq_o pulse, no sample_o).
REQ-032 Without SPIKER_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, err_o SHALL be tied 0 and ERR SHALL be unreachable.

Structure
REQ-033 Package spiker_seq_pkg SHALL hold the state enum typedef and the default STEP_W and TIMEOUT_CYCLES constants.
REQ-034 The timeout counter SHALL be the sub-module spiker_seq_watchdog, instantiated only under SPIKER_SEQ_TIMEOUT_EN.

Verification
REQ-035 n_steps_i=3, core_done_i 4 cycles after each step -> 3 core_step_o pulses, step_cnt_o=3, one sample_o, done_o and irq_o exactly per REQ-023.
REQ-036 start_i with n_steps_i=0 -> the FSM stays in IDLE and no output toggles.
REQ-037 abort_i in the same cycle as core_done_i during step 2 of 5 -> IDLE, one core_clear_o pulse, no sample_o, no irq_o.
REQ-038 TIMEOUT_EN, TIMEOUT_CYCLES=16, core_done_i never asserted -> err_o and irq_o 16 cycles after entering WAIT; ack_i returns the FSM to IDLE.
REQ-039 start_i during WAIT and in the same cycle as ack_i -> ignored; rst_ni asserted in WAIT -> all outputs 0 asynchronously.
